// File: rtl/stream_demultiplexer.sv
// 1:4 registered stream demultiplexer: each input beat is routed to one of four
// one-entry output registers selected by {address1, address0}.
module stream_demultiplexer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             address0,
    input  logic             address1,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [7:0]       drop_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    chan_state_t      state_p1 [4];
    logic [WIDTH-1:0] data_p1  [4];
    logic [1:0]       sel;
    logic             write;

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

    assign sel      = {address1, address0};
    // A full channel can still take a beat when its consumer drains it this cycle.
    assign in_ready = !out_valid[sel] | out_ready[sel];
    assign write    = in_valid & in_ready;

    // Stage p1: per-channel output registers and backpressure counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 4; k++) begin
                state_p1[k] <= EMPTY;
                data_p1[k]  <= '0;
            end
            drop_count <= 8'd0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (write && (sel == 2'(k))) begin
                    state_p1[k] <= FULL;
                    data_p1[k]  <= in_data;
                end else if (out_ready[k]) begin
                    state_p1[k] <= EMPTY;
                end
            end
            if (in_valid && !in_ready) begin
                drop_count <= sat_inc(drop_count);
            end
        end
    end

    always_comb begin
        out_valid = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            out_valid[k] = (state_p1[k] == FULL);
        end
    end

    assign out_data0 = data_p1[0];
    assign out_data1 = data_p1[1];
    assign out_data2 = data_p1[2];
    assign out_data3 = data_p1[3];

endmodule
